// File: rtl/adci_interface.sv
// adci_interface: SPI master for an 8-channel, 12-bit serial ADC (ADC128S022-class).
// Generates CSN/SCK/SDO from sys_clk, deserialises SDI and presents bits [11:4]
// of each conversion on DATA_READ with a one-cycle RX_DONE strobe.
// Optional build macro ADCI_CHAN_SCAN_EN: the address field scans 0..7 on
// successive frames and DATA_CH reports the channel each result belongs to.
module adci_interface #(
  parameter int unsigned SCK_HALF    = 2,
  parameter int unsigned STARTUP_CYC = 1024,
  parameter int unsigned GAP_CYC     = 4,
  parameter logic [2:0]  CHANNEL     = 3'd0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       SDI,
  output logic       CSN,
  output logic       SCK,
  output logic       SDO,
  output logic [7:0] DATA_READ,
`ifdef ADCI_CHAN_SCAN_EN
  output logic [2:0] DATA_CH,
`endif
  output logic       RX_DONE
);

  localparam int unsigned CMAX = (STARTUP_CYC > GAP_CYC) ? STARTUP_CYC : GAP_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned HW   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  localparam logic [CW-1:0] SU_LAST  = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    STARTUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [5:0]    phase_q, phase_d;
  logic [11:0]   rx_q;
  logic [2:0]    addr;
  logic [15:0]   ctrl_word;
  logic [5:0]    adv;
  logic [3:0]    bit_idx;
  logic          csn_d, sck_d, sdo_d;
  logic          sample_en, capture;

  // State and timing counters
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic; phase counts SCK half-periods within a frame (0..32)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = STARTUP;
          cnt_d   = '0;
        end
      end
      STARTUP: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SU_LAST) begin
          state_d = SHIFT;
          hcnt_d  = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d  = '0;
          phase_d = phase_q + 6'd1;
          if (phase_q == 6'd31) begin
            state_d = CS_HOLD;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      CS_HOLD: begin
        if (hcnt_q == H_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (en) begin
            state_d = SHIFT;
            hcnt_d  = '0;
            phase_d = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ctrl_word = {2'b00, addr, 11'b0};

  // Pin values are decoded from the next state so the registered outputs line up
  // with the state. Bit 15 is held through the first SCK fall; each later fall
  // advances one bit, so every rising edge sees bits 15..0 in order.
  always_comb begin
    csn_d   = !((state_d == SHIFT) || (state_d == CS_HOLD));
    sck_d   = (state_d == SHIFT) ? ~phase_d[0] : 1'b1;
    adv     = (phase_d == 6'd0) ? 6'd0 : ((phase_d - 6'd1) >> 1);
    bit_idx = 4'd15 - adv[3:0];
    sdo_d   = csn_d ? 1'b0 : ctrl_word[bit_idx];
  end

  // SDI is taken on the edge that raises SCK; capture fires on the first GAP cycle
  assign sample_en = (state_q == SHIFT) && (hcnt_q == H_LAST) && phase_q[0];
  assign capture   = (state_q == GAP) && (cnt_q == '0);

  // Registered pins, receive shift register and result register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      CSN       <= 1'b1;
      SCK       <= 1'b1;
      SDO       <= 1'b0;
      RX_DONE   <= 1'b0;
      DATA_READ <= '0;
      rx_q      <= '0;
    end else begin
      CSN     <= csn_d;
      SCK     <= sck_d;
      SDO     <= sdo_d;
      RX_DONE <= capture;
      // Only the last 12 bits are kept; the four leading zeros shift out the top
      if (sample_en) begin
        rx_q <= {rx_q[10:0], SDI};
      end
      if (capture) begin
        DATA_READ <= rx_q[11:4];
      end
    end
  end

`ifdef ADCI_CHAN_SCAN_EN
  logic [2:0] scan_q;
  logic [2:0] prev_ch_q;

  // Address scan: the ADC converts the address sent one frame earlier
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= '0;
      prev_ch_q <= '0;
      DATA_CH   <= '0;
    end else if ((state_q != STARTUP) && (state_d == STARTUP)) begin
      scan_q <= '0;
    end else if (capture) begin
      DATA_CH   <= prev_ch_q;
      prev_ch_q <= scan_q;
      scan_q    <= scan_q + 3'd1;
    end
  end

  assign addr = scan_q;
`else
  assign addr = CHANNEL;
`endif

endmodule

// File: tb/tb_adci_interface.sv
// tb_adci_interface: directed self-checking bench for adci_interface
// (SCK_HALF=2, STARTUP_CYC=1024, GAP_CYC=4, CHANNEL=5).
module tb_adci_interface;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       SDI     = 1'b0;
  logic       CSN;
  logic       SCK;
  logic       SDO;
  logic [7:0] DATA_READ;
  logic       RX_DONE;
`ifdef ADCI_CHAN_SCAN_EN
  logic [2:0] DATA_CH;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] adc_word = 16'h0ABC;
  int          adc_bit  = 0;
  logic [2:0]  dch_seen = '0;

  always #5 sys_clk = ~sys_clk;

  adci_interface #(
    .SCK_HALF   (2),
    .STARTUP_CYC(1024),
    .GAP_CYC    (4),
    .CHANNEL    (3'd5)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .en       (en),
    .SDI      (SDI),
    .CSN      (CSN),
    .SCK      (SCK),
    .SDO      (SDO),
    .DATA_READ(DATA_READ),
`ifdef ADCI_CHAN_SCAN_EN
    .DATA_CH  (DATA_CH),
`endif
    .RX_DONE  (RX_DONE)
  );

  // ADC model: next data bit driven on each SCK fall, MSB first
  always @(negedge SCK or negedge CSN) begin
    logic [3:0] idx;
    if (!CSN && SCK) begin
      adc_bit = 0;
    end else if (!CSN) begin
      if (adc_bit < 16) begin
        idx = 4'(15 - adc_bit);
        SDI = adc_word[idx];
      end
      adc_bit++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Count cycles until CSN falls; activity counts any non-idle pin before that
  task automatic wait_csn_fall(input int limit, output int n, output int act);
    n   = -1;
    act = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge sys_clk); #1;
      if (!CSN) begin
        n = i;
        break;
      end
      if (!SCK || SDO || RX_DONE) act++;
    end
  endtask

  // Observe one frame starting at the cycle CSN is first seen low (t=0)
  task automatic measure_frame(input int drop_edge, output int low_len, output int falls,
                               output int rises, output logic [15:0] word, output int done_cnt,
                               output logic [7:0] dr, output int done_at, output int hi_bad,
                               output int period);
    logic prev_sck;
    int   t;
    int   csn_rise;
    low_len  = 1;
    falls    = 0;
    rises    = 0;
    word     = '0;
    done_cnt = 0;
    dr       = '0;
    done_at  = -1;
    hi_bad   = 0;
    period   = -1;
    csn_rise = -1;
    prev_sck = SCK;
    t        = 0;
    while (t < 250) begin
      @(posedge sys_clk); #1;
      t++;
      if (csn_rise < 0) begin
        if (!CSN) begin
          low_len++;
          if (prev_sck && !SCK) falls++;
          if (!prev_sck && SCK) begin
            rises++;
            word = {word[14:0], SDO};
          end
          if (drop_edge >= 0 && (falls + rises) == drop_edge) en = 1'b0;
        end else begin
          csn_rise = t;
        end
      end
      if (RX_DONE) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = (csn_rise < 0) ? -100 : (t - csn_rise);
          dr      = DATA_READ;
`ifdef ADCI_CHAN_SCAN_EN
          dch_seen = DATA_CH;
`endif
        end
      end
      if (csn_rise >= 0) begin
        if (CSN) begin
          if (!SCK || SDO) hi_bad++;
        end else begin
          period = t;
          break;
        end
      end
      prev_sck = SCK;
    end
  endtask

  task automatic test_reset();
    int badcyc;
    badcyc = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (CSN !== 1'b1 || SCK !== 1'b1 || SDO !== 1'b0 || RX_DONE !== 1'b0 || DATA_READ !== 8'h00)
        badcyc++;
    end
    total++;
    if (CSN !== 1'b1) begin bad++; $display("FAIL reset_csn got=%b want=1", CSN); end
    total++;
    if (SCK !== 1'b1) begin bad++; $display("FAIL reset_sck got=%b want=1", SCK); end
    total++;
    if (SDO !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", SDO); end
    total++;
    if (DATA_READ !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", DATA_READ); end
    total++;
    if (RX_DONE !== 1'b0) begin bad++; $display("FAIL reset_rx_done got=%b want=0", RX_DONE); end
    total++;
    if (badcyc != 0) begin bad++; $display("FAIL reset_activity got=%0d want=0", badcyc); end
  endtask

  task automatic test_startup();
    int n, act;
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    wait_csn_fall(1200, n, act);
    total++;
    if (n != 1024) begin bad++; $display("FAIL startup_delay got=%0d want=1024", n); end
    total++;
    if (act != 0) begin bad++; $display("FAIL startup_activity got=%0d want=0", act); end
  endtask

  task automatic test_frame_shape();
    int low_len, falls, rises, done_cnt, done_at, hi_bad, period;
    logic [15:0] word;
    logic [7:0]  dr;
    measure_frame(-1, low_len, falls, rises, word, done_cnt, dr, done_at, hi_bad, period);
    total++;
    if (low_len != 66) begin bad++; $display("FAIL shape_csn_low got=%0d want=66", low_len); end
    total++;
    if (falls != 16) begin bad++; $display("FAIL shape_sck_falls got=%0d want=16", falls); end
    total++;
    if (rises != 16) begin bad++; $display("FAIL shape_sck_rises got=%0d want=16", rises); end
    total++;
    if (hi_bad != 0) begin bad++; $display("FAIL shape_idle_pins got=%0d want=0", hi_bad); end
    total++;
    if (period != 70) begin bad++; $display("FAIL shape_period got=%0d want=70", period); end
  endtask

  task automatic test_data();
    logic [15:0] pats [3];
    logic [7:0]  exps [3];
    int low_len, falls, rises, done_cnt, done_at, hi_bad, period;
    logic [15:0] word;
    logic [7:0]  dr;
    pats[0] = 16'h0ABC; exps[0] = 8'hAB;
    pats[1] = 16'h0FFF; exps[1] = 8'hFF;
    pats[2] = 16'h000F; exps[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      adc_word = pats[i];
      measure_frame(-1, low_len, falls, rises, word, done_cnt, dr, done_at, hi_bad, period);
      total++;
      if (dr !== exps[i]) begin bad++; $display("FAIL data_%0d got=%h want=%h", i, dr, exps[i]); end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL data_pulses_%0d got=%0d want=1", i, done_cnt); end
      total++;
      if (done_at != 1) begin bad++; $display("FAIL data_done_delay_%0d got=%0d want=1", i, done_at); end
    end
  endtask

`ifndef ADCI_CHAN_SCAN_EN
  task automatic test_ctrl_word();
    int low_len, falls, rises, done_cnt, done_at, hi_bad, period;
    logic [15:0] word;
    logic [7:0]  dr;
    measure_frame(-1, low_len, falls, rises, word, done_cnt, dr, done_at, hi_bad, period);
    total++;
    if (word !== 16'h2800) begin bad++; $display("FAIL ctrl_word got=%h want=2800", word); end
    total++;
    if (hi_bad != 0) begin bad++; $display("FAIL ctrl_sdo_idle got=%0d want=0", hi_bad); end
  endtask
`endif

  task automatic test_en_drop();
    int low_len, falls, rises, done_cnt, done_at, hi_bad, period;
    logic [15:0] word;
    logic [7:0]  dr;
    adc_word = 16'h0123;
    measure_frame(8, low_len, falls, rises, word, done_cnt, dr, done_at, hi_bad, period);
    total++;
    if (low_len != 66) begin bad++; $display("FAIL endrop_csn_low got=%0d want=66", low_len); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL endrop_pulses got=%0d want=1", done_cnt); end
    total++;
    if (dr !== 8'h12) begin bad++; $display("FAIL endrop_data got=%h want=12", dr); end
    total++;
    if (period != -1 || hi_bad != 0)
      begin bad++; $display("FAIL endrop_idle got=period %0d/bad %0d want=-1/0", period, hi_bad); end
  endtask

  task automatic test_reenable();
    int n, act;
    @(negedge sys_clk);
    en = 1'b1;
    @(posedge sys_clk); #1;
    wait_csn_fall(1200, n, act);
    total++;
    if (n != 1024) begin bad++; $display("FAIL reenable_delay got=%0d want=1024", n); end
    total++;
    if (act != 0) begin bad++; $display("FAIL reenable_activity got=%0d want=0", act); end
  endtask

`ifdef ADCI_CHAN_SCAN_EN
  task automatic test_scan();
    int low_len, falls, rises, done_cnt, done_at, hi_bad, period;
    logic [15:0] word;
    logic [7:0]  dr;
    logic [2:0]  exp_addr, exp_ch;
    for (int i = 0; i < 9; i++) begin
      measure_frame(-1, low_len, falls, rises, word, done_cnt, dr, done_at, hi_bad, period);
      exp_addr = 3'(i);
      total++;
      if (word[13:11] !== exp_addr)
        begin bad++; $display("FAIL scan_addr_%0d got=%0d want=%0d", i, word[13:11], exp_addr); end
      if (i > 0) begin
        exp_ch = 3'(i - 1);
        total++;
        if (dch_seen !== exp_ch)
          begin bad++; $display("FAIL scan_ch_%0d got=%0d want=%0d", i, dch_seen, exp_ch); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_frame_shape();
    test_data();
`ifndef ADCI_CHAN_SCAN_EN
    test_ctrl_word();
`endif
    test_en_drop();
    test_reenable();
`ifdef ADCI_CHAN_SCAN_EN
    test_scan();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
